// File: rtl/uart_link_pkg.sv
// uart_link_pkg: FSM state encodings and oversampling constants shared by the UART link.
package uart_link_pkg;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_MID = 7;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: first-word-fall-through FIFO with wrap-bit pointers; holds the last popped word when empty.
module uart_sync_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr,
  input  logic [DATA_BITS-1:0] w_data,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] r_data,
  output logic                 full,
  output logic                 empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wp, r_rp;
  logic [DATA_BITS-1:0] r_last;
  logic w_wr, w_rd;
  assign empty = r_wp == r_rp;
  assign full = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_rd = rd && !empty;
  // a read frees the slot being written when full, so both may proceed
  assign w_wr = wr && (!full || w_rd);
  assign r_data = empty ? r_last : r_mem[r_rp[AW-1:0]];
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp[AW-1:0]] <= w_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wp <= '0;
      r_rp <= '0;
      r_last <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) begin
        r_rp <= r_rp + 1'b1;
        r_last <= r_data;
      end
    end
endmodule

// File: rtl/uart_link.sv
// uart_link: full-duplex UART with runtime baud divisor, parity, 1/2 stop bits and sticky error flags.
// Optional internal TX->RX loopback port when UART_LINK_LOOPBACK_EN is defined.
module uart_link
  import uart_link_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef UART_LINK_LOOPBACK_EN
  input  logic                 loopback,
`endif
  input  logic [DIV_W-1:0]     divisor,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 stop2,
  input  logic                 wr_uart,
  input  logic [DATA_BITS-1:0] w_data,
  output logic                 tx_full,
  input  logic                 rd_uart,
  output logic [DATA_BITS-1:0] r_data,
  output logic                 rx_empty,
  input  logic                 rx,
  output logic                 tx,
  output logic                 tx_busy,
  input  logic                 clr_err,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err
);
  logic [DIV_W-1:0] r_div_cnt, r_div_last;
  logic w_tick;
  assign w_tick = (r_div_cnt == divisor) && (divisor == r_div_last);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_div_cnt <= '0;
      r_div_last <= '0;
    end else begin
      r_div_last <= divisor;
      r_div_cnt <= (divisor != r_div_last || w_tick) ? '0 : r_div_cnt + 1'b1;
    end
  tx_state_t r_tx_state, w_tx_state_n;
  logic [4:0] r_tx_tcnt, w_tx_tcnt_n;
  logic [3:0] r_tx_bcnt, w_tx_bcnt_n;
  logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_n, w_tx_head;
  logic r_tx_par, w_tx_par_n, r_tx_pen, w_tx_pen_n, r_tx_stop2, w_tx_stop2_n;
  logic w_tx_pop, w_tx_empty, w_tx_line, w_tx_bit_end, w_tx_stop_end;
  assign w_tx_bit_end = w_tick && r_tx_tcnt == 5'(OVERSAMPLE-1);
  assign w_tx_stop_end = w_tick && r_tx_tcnt == (r_tx_stop2 ? 5'(2*OVERSAMPLE-1) : 5'(OVERSAMPLE-1));
  always_comb begin
    w_tx_state_n = r_tx_state;
    w_tx_tcnt_n = (r_tx_state != TX_IDLE && w_tick) ? r_tx_tcnt + 1'b1 : r_tx_tcnt;
    w_tx_bcnt_n = r_tx_bcnt;
    w_tx_shift_n = r_tx_shift;
    w_tx_par_n = r_tx_par;
    w_tx_pen_n = r_tx_pen;
    w_tx_stop2_n = r_tx_stop2;
    w_tx_pop = 1'b0;
    w_tx_line = 1'b1;
    case (r_tx_state)
      TX_START: begin
        w_tx_line = 1'b0;
        if (w_tx_bit_end) begin
          w_tx_tcnt_n = '0;
          w_tx_state_n = TX_DATA;
        end
      end
      TX_DATA: begin
        w_tx_line = r_tx_shift[0];
        if (w_tx_bit_end) begin
          w_tx_tcnt_n = '0;
          w_tx_shift_n = r_tx_shift >> 1;
          w_tx_bcnt_n = r_tx_bcnt + 1'b1;
          if (r_tx_bcnt == 4'(DATA_BITS-1)) begin
            w_tx_bcnt_n = '0;
            w_tx_state_n = r_tx_pen ? TX_PARITY : TX_STOP;
          end
        end
      end
      TX_PARITY: begin
        w_tx_line = r_tx_par;
        if (w_tx_bit_end) begin
          w_tx_tcnt_n = '0;
          w_tx_state_n = TX_STOP;
        end
      end
      TX_STOP:
        if (w_tx_stop_end) begin
          w_tx_tcnt_n = '0;
          w_tx_state_n = TX_IDLE;
        end
      default: ;
    endcase
    // frame start, either from IDLE or back-to-back at the end of STOP
    if (w_tick && !w_tx_empty && (r_tx_state == TX_IDLE || (r_tx_state == TX_STOP && w_tx_stop_end))) begin
      w_tx_pop = 1'b1;
      w_tx_state_n = TX_START;
      w_tx_tcnt_n = '0;
      w_tx_shift_n = w_tx_head;
      w_tx_par_n = ^w_tx_head ^ parity_odd;
      w_tx_pen_n = parity_en;
      w_tx_stop2_n = stop2;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_tcnt <= '0;
      r_tx_bcnt <= '0;
      r_tx_shift <= '0;
      r_tx_par <= 1'b0;
      r_tx_pen <= 1'b0;
      r_tx_stop2 <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_n;
      r_tx_tcnt <= w_tx_tcnt_n;
      r_tx_bcnt <= w_tx_bcnt_n;
      r_tx_shift <= w_tx_shift_n;
      r_tx_par <= w_tx_par_n;
      r_tx_pen <= w_tx_pen_n;
      r_tx_stop2 <= w_tx_stop2_n;
    end
  assign tx_busy = r_tx_state != TX_IDLE;
  uart_sync_fifo #(.DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .wr(wr_uart), .w_data(w_data), .rd(w_tx_pop),
    .r_data(w_tx_head), .full(tx_full), .empty(w_tx_empty)
  );
  logic w_rx_in;
`ifdef UART_LINK_LOOPBACK_EN
  assign tx = loopback ? 1'b1 : w_tx_line;
  assign w_rx_in = loopback ? w_tx_line : rx;
`else
  assign tx = w_tx_line;
  assign w_rx_in = rx;
`endif
  logic [1:0] r_sync;
  logic w_rx_s;
  assign w_rx_s = r_sync[1];
  rx_state_t r_rx_state, w_rx_state_n;
  logic [3:0] r_rx_tcnt, w_rx_tcnt_n, r_rx_bcnt, w_rx_bcnt_n;
  logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_n;
  logic r_rx_pen, w_rx_pen_n, r_rx_podd, w_rx_podd_n, r_rx_pbit, w_rx_pbit_n;
  logic r_rx_done, w_rx_done_n, r_rx_stop, w_rx_stop_n;
  logic w_rx_mid, w_rx_end, w_rx_full, w_par_bad;
  assign w_rx_mid = w_tick && r_rx_tcnt == 4'(SAMPLE_MID);
  assign w_rx_end = w_tick && r_rx_tcnt == 4'(OVERSAMPLE-1);
  always_comb begin
    w_rx_state_n = r_rx_state;
    w_rx_tcnt_n = (r_rx_state != RX_IDLE && w_tick) ? r_rx_tcnt + 1'b1 : r_rx_tcnt;
    w_rx_bcnt_n = r_rx_bcnt;
    w_rx_shift_n = r_rx_shift;
    w_rx_pen_n = r_rx_pen;
    w_rx_podd_n = r_rx_podd;
    w_rx_pbit_n = r_rx_pbit;
    w_rx_done_n = 1'b0;
    w_rx_stop_n = r_rx_stop;
    case (r_rx_state)
      RX_IDLE:
        if (!w_rx_s) begin
          w_rx_state_n = RX_START;
          w_rx_tcnt_n = '0;
          w_rx_pen_n = parity_en;
          w_rx_podd_n = parity_odd;
        end
      RX_START:
        if (w_rx_mid) begin
          w_rx_tcnt_n = '0;
          w_rx_state_n = w_rx_s ? RX_IDLE : RX_DATA;
        end
      RX_DATA:
        if (w_rx_end) begin
          w_rx_shift_n = {w_rx_s, r_rx_shift[DATA_BITS-1:1]};
          w_rx_bcnt_n = r_rx_bcnt + 1'b1;
          if (r_rx_bcnt == 4'(DATA_BITS-1)) begin
            w_rx_bcnt_n = '0;
            w_rx_state_n = r_rx_pen ? RX_PARITY : RX_STOP;
          end
        end
      RX_PARITY:
        if (w_rx_end) begin
          w_rx_pbit_n = w_rx_s;
          w_rx_state_n = RX_STOP;
        end
      RX_STOP:
        if (w_rx_end) begin
          w_rx_done_n = 1'b1;
          w_rx_stop_n = w_rx_s;
          w_rx_state_n = RX_IDLE;
        end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_sync <= 2'b11;
      r_rx_state <= RX_IDLE;
      r_rx_tcnt <= '0;
      r_rx_bcnt <= '0;
      r_rx_shift <= '0;
      r_rx_pen <= 1'b0;
      r_rx_podd <= 1'b0;
      r_rx_pbit <= 1'b0;
      r_rx_done <= 1'b0;
      r_rx_stop <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], w_rx_in};
      r_rx_state <= w_rx_state_n;
      r_rx_tcnt <= w_rx_tcnt_n;
      r_rx_bcnt <= w_rx_bcnt_n;
      r_rx_shift <= w_rx_shift_n;
      r_rx_pen <= w_rx_pen_n;
      r_rx_podd <= w_rx_podd_n;
      r_rx_pbit <= w_rx_pbit_n;
      r_rx_done <= w_rx_done_n;
      r_rx_stop <= w_rx_stop_n;
    end
  uart_sync_fifo #(.DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .wr(r_rx_done), .w_data(r_rx_shift), .rd(rd_uart),
    .r_data(r_data), .full(w_rx_full), .empty(rx_empty)
  );
  assign w_par_bad = r_rx_pen && (r_rx_pbit != (^r_rx_shift ^ r_rx_podd));
  logic r_parity_err, r_frame_err, r_overrun_err;
  // a new error event wins over a same-cycle clear
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_parity_err <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_parity_err <= (r_rx_done && w_par_bad) || (r_parity_err && !clr_err);
      r_frame_err <= (r_rx_done && !r_rx_stop) || (r_frame_err && !clr_err);
      r_overrun_err <= (r_rx_done && w_rx_full && !rd_uart) || (r_overrun_err && !clr_err);
    end
  assign parity_err = r_parity_err;
  assign frame_err = r_frame_err;
  assign overrun_err = r_overrun_err;
endmodule
